// File: rtl/pwm_capture_16bits_pkg.sv
// Shared types and widths for the PWM capture block.
package pwm_capture_16bits_pkg;

  localparam int unsigned CAPCOUNT_WIDTH = 16;

  // Wide enough for FILT_LEN up to 15.
  localparam int unsigned FILT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } _cap_state;

endpackage

// File: rtl/pwm_input_filter.sv
// Input conditioning for the capture block: synchronizer, polarity select,
// run-length glitch filter and single-cycle edge pulses.
module pwm_input_filter
  import pwm_capture_16bits_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic polarity,
  input  logic pwm_in,
  output logic rise_p,
  output logic fall_p
);

  localparam logic [FILT_CNT_W-1:0] RUN_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   filt_q;
  logic                   filt_d;
  logic [FILT_CNT_W-1:0]  run_cnt;

  assign sample = sync_q[SYNC_STAGES-1] ^ polarity;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      filt_q  <= 1'b0;
      filt_d  <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      filt_d <= filt_q;
      // run_cnt counts consecutive samples disagreeing with the accepted level
      if (sample == filt_q) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_LAST) begin
        filt_q  <= sample;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + FILT_CNT_W'(1);
      end
    end
  end

  assign rise_p = filt_q & ~filt_d;
  assign fall_p = ~filt_q & filt_d;

endmodule

// File: rtl/pwm_capture_16bits.sv
// PWM capture: measures high time and rise-to-rise period of an external
// PWM input in clk cycles, with saturation timeout.
module pwm_capture_16bits
  import pwm_capture_16bits_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CAPCOUNT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_en,
  input  logic                 polarity,
  input  logic                 clear,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  _cap_state            state, state_nxt;
  logic                 rise_p, fall_p;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hi_lat;
  logic                 cnt_sat;
  logic                 set_valid;
  logic                 set_timeout;

  pwm_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .pwm_in   (pwm_in),
    .rise_p   (rise_p),
    .fall_p   (fall_p)
  );

  assign cnt_sat = (cnt == CNT_MAX);
  assign busy    = (state == MEAS_HIGH) || (state == MEAS_LOW);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    set_valid   = 1'b0;
    set_timeout = 1'b0;
    if (!capture_en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nxt = WAIT_RISE;
        WAIT_RISE: if (rise_p) state_nxt = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall_p) begin
            state_nxt = MEAS_LOW;
          end else if (cnt_sat) begin
            state_nxt   = WAIT_RISE;
            set_timeout = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise_p) begin
            state_nxt = MEAS_HIGH;
            set_valid = 1'b1;
          end else if (cnt_sat) begin
            state_nxt   = WAIT_RISE;
            set_timeout = 1'b1;
          end
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      hi_lat     <= '0;
      high_time  <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (rise_p) begin
        cnt <= CNT_WIDTH'(1);
      end else if (busy && !cnt_sat) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end

      if (state == MEAS_HIGH && fall_p && capture_en) hi_lat <= cnt;

      meas_valid <= set_valid;
      if (set_valid) begin
        period    <= cnt;
        high_time <= hi_lat;
      end

      // A timeout raised in the same cycle as clear must stay set.
      if (set_timeout)  timeout <= 1'b1;
      else if (clear)   timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Directed bench for pwm_capture_16bits: table of waveforms plus hand-written
// sequences for timeout, capture abort and mid-measurement reset.
module tb_pwm_capture_16bits;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        polarity;
  logic        clear;
  logic        pwm_in;
  logic [15:0] high_time;
  logic [15:0] period;
  logic        meas_valid;
  logic        timeout;
  logic        busy;

  always #5 clk = ~clk;

  pwm_capture_16bits #(
    .CNT_WIDTH   (16),
    .SYNC_STAGES (2),
    .FILT_LEN    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .polarity   (polarity),
    .clear      (clear),
    .pwm_in     (pwm_in),
    .high_time  (high_time),
    .period     (period),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc       = 0;
  int unsigned vcount    = 0;
  int unsigned last_vcyc = 0;
  int unsigned prev_vcyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid) begin
      vcount    <= vcount + 1;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc;
    end
  end

  typedef struct {
    bit          pol;
    int unsigned hi;
    int unsigned lo;
    bit          glitch;
    int unsigned exp_hi;
    int unsigned exp_per;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int unsigned n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo, input bit glitch);
    if (glitch) begin
      hold(1'b1, hi / 3);
      hold(1'b0, 2);
      hold(1'b1, hi - hi / 3 - 2);
    end else begin
      hold(1'b1, hi);
    end
    hold(1'b0, lo);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got time-out expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base;

    vecs[0] = '{pol: 1'b0, hi: 30,  lo: 70, glitch: 1'b0, exp_hi: 30, exp_per: 100};
    vecs[1] = '{pol: 1'b0, hi: 30,  lo: 70, glitch: 1'b1, exp_hi: 30, exp_per: 100};
    vecs[2] = '{pol: 1'b1, hi: 30,  lo: 70, glitch: 1'b0, exp_hi: 70, exp_per: 100};
    vecs[3] = '{pol: 1'b0, hi: 5,   lo: 10, glitch: 1'b0, exp_hi: 5,  exp_per: 15};
    vecs[4] = '{pol: 1'b0, hi: 3,   lo: 3,  glitch: 1'b0, exp_hi: 3,  exp_per: 6};
    vecs[5] = '{pol: 1'b1, hi: 200, lo: 50, glitch: 1'b0, exp_hi: 50, exp_per: 250};

    reset      = 1'b1;
    capture_en = 1'b0;
    polarity   = 1'b0;
    clear      = 1'b0;
    pwm_in     = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_high_time", high_time, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    hold(1'b0, 5);

    for (int i = 0; i < 6; i++) begin
      capture_en = 1'b0;
      hold(1'b0, 5);
      polarity = vecs[i].pol;
      hold(1'b0, 10);
      capture_en = 1'b1;
      hold(1'b0, 3);
      base = vcount;
      for (int p = 0; p < 5; p++) pulse(vecs[i].hi, vecs[i].lo, vecs[i].glitch);
      hold(1'b0, 20);
      chk($sformatf("vec%0d_count", i), vcount - base, 4);
      chk($sformatf("vec%0d_high_time", i), high_time, vecs[i].exp_hi);
      chk($sformatf("vec%0d_period", i), period, vecs[i].exp_per);
      chk($sformatf("vec%0d_spacing", i), last_vcyc - prev_vcyc, vecs[i].hi + vecs[i].lo);
    end

    // Stuck-high input saturates the counter.
    capture_en = 1'b0;
    polarity   = 1'b0;
    hold(1'b0, 10);
    capture_en = 1'b1;
    hold(1'b0, 5);
    base = vcount;
    hold(1'b1, 65600);
    chk("to_timeout", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_no_valid", vcount - base, 0);
    chk("to_hold_high_time", high_time, 50);
    chk("to_hold_period", period, 250);
    hold(1'b1, 10);
    chk("to_sticky", timeout, 1);
    clear = 1'b1;
    hold(1'b1, 1);
    clear = 1'b0;
    hold(1'b1, 2);
    chk("to_cleared", timeout, 0);
    hold(1'b0, 20);

    // Abort mid MEAS_LOW, then re-enable.
    capture_en = 1'b0;
    hold(1'b0, 5);
    capture_en = 1'b1;
    hold(1'b0, 5);
    base = vcount;
    pulse(30, 70, 1'b0);
    pulse(30, 70, 1'b0);
    hold(1'b1, 30);
    hold(1'b0, 20);
    chk("abort_pre_count", vcount - base, 2);
    chk("abort_pre_busy", busy, 1);
    capture_en = 1'b0;
    hold(1'b0, 50);
    pulse(30, 70, 1'b0);
    chk("abort_no_valid", vcount - base, 2);
    chk("abort_busy", busy, 0);
    chk("abort_hold_high_time", high_time, 30);
    chk("abort_hold_period", period, 100);
    capture_en = 1'b1;
    hold(1'b0, 3);
    base = vcount;
    pulse(20, 60, 1'b0);
    chk("reen_first_rise_no_valid", vcount - base, 0);
    hold(1'b1, 20);
    hold(1'b0, 20);
    chk("reen_count", vcount - base, 1);
    chk("reen_high_time", high_time, 20);
    chk("reen_period", period, 80);

    // Reset during MEAS_HIGH.
    pulse(40, 60, 1'b0);
    hold(1'b1, 10);
    chk("mid_busy", busy, 1);
    chk("mid_high_time", high_time, 40);
    base   = vcount;
    reset  = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_high_time", high_time, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_valid", meas_valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    hold(1'b0, 20);
    chk("mid_rst_no_valid", vcount - base, 0);
    base = vcount;
    pulse(25, 75, 1'b0);
    pulse(25, 75, 1'b0);
    hold(1'b1, 10);
    hold(1'b0, 20);
    chk("restart_count", vcount - base, 2);
    chk("restart_high_time", high_time, 25);
    chk("restart_period", period, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
